// File: rtl/pl_reset_pkg.sv
// Shared FSM state type, reset-cause encodings and default parameters for the PL reset requester.
package pl_reset_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_HOLDOFF
    } state_e;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;
    localparam logic [1:0] CAUSE_BOTH = 2'b11;

    localparam int unsigned DEF_PULSE_CYCLES   = 16;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 64;
    localparam int unsigned DEF_ACK_TIMEOUT    = 4096;
    localparam int unsigned DEF_WDT_CYCLES     = 1024;
    localparam int unsigned DEF_CNT_W          = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned bits_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pl_reset_wdt.sv
// Watchdog counter: runs while enabled, restarts on kick, flags expiry at WDT_CYCLES-1.
module pl_reset_wdt
    import pl_reset_pkg::*;
#(
    parameter int unsigned WDT_CYCLES = DEF_WDT_CYCLES
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic run,
    input  logic kick,
    input  logic clear,
    output logic expire_c
);

    localparam int unsigned W = bits_for(WDT_CYCLES - 1);
    localparam logic [W-1:0] LAST = W'(WDT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    // A kick in the expiry cycle suppresses the expiry.
    assign expire_c = run && !kick && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (sys_reset || !run || kick || clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/pl_reset_requester.sv
// Stretched, acknowledged ext_reset_in request generator for the PL reset block.
// Optional watchdog source is built only when PL_RESET_REQ_WDT_EN is defined.
module pl_reset_requester
    import pl_reset_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int unsigned ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
    parameter int unsigned WDT_CYCLES     = DEF_WDT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             slowest_sync_clk,
    input  logic             sys_reset,
    input  logic             sw_reset_req,
    input  logic             wdt_enable,
    input  logic             wdt_kick,
    input  logic             peripheral_aresetn,
    output logic             ext_reset_in,
    output logic             busy,
    output logic             req_ack,
    output logic             reset_done,
    output logic             ack_timeout,
    output logic [1:0]       reset_cause,
    output logic [CNT_W-1:0] reset_count
);

    // Shared sequence counter; one extra value of headroom for the timeout budget.
    localparam int unsigned SEQ_MAX = max3(PULSE_CYCLES - 1, HOLDOFF_CYCLES - 1, ACK_TIMEOUT);
    localparam int unsigned SEQ_W   = bits_for(SEQ_MAX);
    localparam logic [SEQ_W-1:0] PULSE_LOAD = SEQ_W'(PULSE_CYCLES - 1);
    localparam logic [SEQ_W-1:0] HOLD_LOAD  = SEQ_W'(HOLDOFF_CYCLES - 1);
    localparam logic [SEQ_W-1:0] ACK_LAST   = SEQ_W'(ACK_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             pend_q, pend_d;
    logic             launch_c, done_c, timeout_c, sw_c, wdt_exp_c;
    logic [1:0]       cause_c;

`ifdef PL_RESET_REQ_WDT_EN
    logic wdt_run_c;
    assign wdt_run_c = (state_q == ST_IDLE) && wdt_enable;

    pl_reset_wdt #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk       (slowest_sync_clk),
        .sys_reset (sys_reset),
        .run       (wdt_run_c),
        .kick      (wdt_kick),
        .clear     (launch_c),
        .expire_c  (wdt_exp_c)
    );
`else
    logic unused_wdt;
    assign unused_wdt = ^{wdt_enable, wdt_kick, WDT_CYCLES};
    assign wdt_exp_c  = 1'b0;
`endif

    assign sw_c = sw_reset_req || pend_q;

    // Next-state and per-cycle event logic.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        pend_d    = pend_q;
        launch_c  = 1'b0;
        done_c    = 1'b0;
        timeout_c = 1'b0;
        cause_c   = CAUSE_NONE;

        if (sw_c && wdt_exp_c) begin
            cause_c = CAUSE_BOTH;
        end else if (wdt_exp_c) begin
            cause_c = CAUSE_WDT;
        end else if (sw_c) begin
            cause_c = CAUSE_SW;
        end

        if (state_q != ST_IDLE && sw_reset_req) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sw_c || wdt_exp_c) begin
                    launch_c = 1'b1;
                    pend_d   = 1'b0;
                    seq_d    = PULSE_LOAD;
                    state_d  = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (seq_q == '0) begin
                    seq_d   = '0;
                    state_d = ST_WAIT_LOW;
                end else begin
                    seq_d = seq_q - SEQ_W'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (!peripheral_aresetn) begin
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = ST_WAIT_HIGH;
                end else if (seq_q >= ACK_LAST) begin
                    timeout_c = 1'b1;
                    seq_d     = HOLD_LOAD;
                    state_d   = ST_HOLDOFF;
                end else begin
                    seq_d = seq_q + SEQ_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (peripheral_aresetn) begin
                    done_c  = 1'b1;
                    seq_d   = HOLD_LOAD;
                    state_d = ST_HOLDOFF;
                end else if (seq_q >= ACK_LAST) begin
                    timeout_c = 1'b1;
                    seq_d     = HOLD_LOAD;
                    state_d   = ST_HOLDOFF;
                end else begin
                    seq_d = seq_q + SEQ_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (seq_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    seq_d = seq_q - SEQ_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                seq_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge slowest_sync_clk) begin
        if (sys_reset) begin
            state_q      <= ST_IDLE;
            seq_q        <= '0;
            pend_q       <= 1'b0;
            ext_reset_in <= 1'b1;
            busy         <= 1'b0;
            req_ack      <= 1'b0;
            reset_done   <= 1'b0;
            ack_timeout  <= 1'b0;
            reset_cause  <= CAUSE_NONE;
            reset_count  <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            pend_q       <= pend_d;
            ext_reset_in <= (state_d != ST_ASSERT);
            busy         <= (state_d != ST_IDLE);
            req_ack      <= launch_c;
            reset_done   <= done_c;
            if (timeout_c) begin
                ack_timeout <= 1'b1;
            end
            if (launch_c) begin
                reset_cause <= cause_c;
            end
            if (done_c && (reset_count != {CNT_W{1'b1}})) begin
                reset_count <= reset_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pl_reset_requester.sv
// Scoreboard bench for pl_reset_requester: stimulus pushes expected events, a monitor pops and compares.
`timescale 1ns/1ps
module tb_pl_reset_requester;
    import pl_reset_pkg::*;

    logic       slowest_sync_clk = 1'b0;
    logic       sys_reset = 1'b1;
    logic       sw_reset_req = 1'b0;
    logic       wdt_enable = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       peripheral_aresetn = 1'b1;
    logic       ext_reset_in, busy, req_ack, reset_done, ack_timeout;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    pl_reset_requester dut (
        .slowest_sync_clk   (slowest_sync_clk),
        .sys_reset          (sys_reset),
        .sw_reset_req       (sw_reset_req),
        .wdt_enable         (wdt_enable),
        .wdt_kick           (wdt_kick),
        .peripheral_aresetn (peripheral_aresetn),
        .ext_reset_in       (ext_reset_in),
        .busy               (busy),
        .req_ack            (req_ack),
        .reset_done         (reset_done),
        .ack_timeout        (ack_timeout),
        .reset_cause        (reset_cause),
        .reset_count        (reset_count)
    );

    always #5 slowest_sync_clk = ~slowest_sync_clk;

    // cyc = edges seen so far; the cycle observed at a negedge is cyc+1.
    int cyc = 0;
    always @(posedge slowest_sync_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t q_ack[$];
    exp_t q_done[$];
    int   q_to[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_count = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    // Reset-block model: aresetn drops 19 cycles after ext_reset_in falls and rises 30 cycles later.
    int   fall_c = -1000;
    logic prev_ext = 1'b1;
    bit   fb_stuck = 1'b0;
    always @(negedge slowest_sync_clk) begin
        prev_ext <= ext_reset_in;
        if (prev_ext && !ext_reset_in) fall_c <= cyc + 1;
        if (fb_stuck || (cyc + 1 == fall_c + 49)) peripheral_aresetn <= 1'b1;
        else if (cyc + 1 == fall_c + 19) peripheral_aresetn <= 1'b0;
    end

    // Monitor: every output event must match the head of its queue.
    logic prev_to = 1'b0;
    always @(negedge slowest_sync_clk) begin
        exp_t e;
        if (req_ack) begin
            if (q_ack.size() == 0) chk("unexpected req_ack", int'(req_ack), 0);
            else begin
                e = q_ack.pop_front();
                chk("req_ack cycle", cyc + 1, e.cyc);
                chk("reset_cause", int'(reset_cause), int'(e.val));
            end
        end
        if (reset_done) begin
            if (q_done.size() == 0) chk("unexpected reset_done", int'(reset_done), 0);
            else begin
                e = q_done.pop_front();
                chk("reset_done cycle", cyc + 1, e.cyc);
                chk("reset_count", int'(reset_count), int'(e.val));
            end
        end
        if (ack_timeout && !prev_to) begin
            if (q_to.size() == 0) chk("unexpected ack_timeout", int'(ack_timeout), 0);
            else chk("ack_timeout cycle", cyc + 1, q_to.pop_front());
        end
        prev_to <= ack_timeout;
    end

    task automatic to_cycle(input int c);
        while (cyc + 1 < c) @(negedge slowest_sync_clk);
    endtask

    task automatic pulse_sw(input int c);
        to_cycle(c);
        sw_reset_req = 1'b1;
        @(negedge slowest_sync_clk);
        sw_reset_req = 1'b0;
    endtask

    task automatic pulse_kick(input int c);
        to_cycle(c);
        wdt_kick = 1'b1;
        @(negedge slowest_sync_clk);
        wdt_kick = 1'b0;
    endtask

    // Launch sampled at edge c: ack in c+1; with normal feedback, done in c+51.
    task automatic expect_seq(input int c, input logic [1:0] cause, input bit completes);
        exp_t e;
        e.cyc = c + 1;
        e.val = {6'd0, cause};
        q_ack.push_back(e);
        if (completes) begin
            if (exp_count < 255) exp_count++;
            e.cyc = c + 51;
            e.val = 8'(exp_count);
            q_done.push_back(e);
        end
    endtask

    initial begin
        int c;
        int base;
        @(negedge slowest_sync_clk);

        // Reset values
        to_cycle(4);
        sys_reset = 1'b0;
        chk("reset ext_reset_in", int'(ext_reset_in), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset ack_timeout", int'(ack_timeout), 0);
        chk("reset cause", int'(reset_cause), 0);
        chk("reset count", int'(reset_count), 0);

        // Single software request at edge 10
        expect_seq(10, CAUSE_SW, 1'b1);
        pulse_sw(10);
        to_cycle(11);  chk("ext low c11", int'(ext_reset_in), 0); chk("busy c11", int'(busy), 1);
        to_cycle(26);  chk("ext low c26", int'(ext_reset_in), 0);
        to_cycle(27);  chk("ext high c27", int'(ext_reset_in), 1);
        to_cycle(124); chk("busy c124", int'(busy), 1);
        to_cycle(125); chk("busy c125", int'(busy), 0);
        chk("count after t1", int'(reset_count), 1);

        // Requests during ASSERT collapse into one pending relaunch
        expect_seq(140, CAUSE_SW, 1'b1);
        pulse_sw(140);
        pulse_sw(143);
        pulse_sw(146);
        pulse_sw(149);
        expect_seq(255, CAUSE_SW, 1'b1);
        to_cycle(255); chk("idle gap busy", int'(busy), 0);
        to_cycle(256); chk("relaunch busy", int'(busy), 1);
        to_cycle(370); chk("busy after relaunch", int'(busy), 0);
        chk("count after t3", int'(reset_count), 2 + 1);

        // sys_reset in the middle of ASSERT, with a pending request
        expect_seq(400, CAUSE_SW, 1'b0);
        pulse_sw(400);
        pulse_sw(403);
        to_cycle(405); sys_reset = 1'b1;
        to_cycle(406); sys_reset = 1'b0;
        exp_count = 0;
        chk("sysrst ext", int'(ext_reset_in), 1);
        chk("sysrst busy", int'(busy), 0);
        chk("sysrst cause", int'(reset_cause), 0);
        chk("sysrst count", int'(reset_count), 0);
        to_cycle(700); chk("no launch after sysrst", int'(busy), 0);

`ifdef PL_RESET_REQ_WDT_EN
        // Expiry with no kicks
        to_cycle(710); wdt_enable = 1'b1;
        expect_seq(1733, CAUSE_WDT, 1'b1);
        to_cycle(800); wdt_enable = 1'b0;
        to_cycle(1850); chk("wdt seq done", int'(busy), 0);
        // Regular kicks keep it quiet
        to_cycle(1860); wdt_enable = 1'b1;
        for (int k = 1; k <= 5; k++) pulse_kick(1860 + 500 * k);
        to_cycle(4600); wdt_enable = 1'b0;
        chk("kicked wdt idle", int'(busy), 0);
        // Kick in the expiry cycle wins
        to_cycle(4610); wdt_enable = 1'b1;
        pulse_kick(4610 + 1023);
        to_cycle(5700); wdt_enable = 1'b0;
        chk("kick wins idle", int'(busy), 0);
        // Same-cycle software request and expiry
        to_cycle(5710); wdt_enable = 1'b1;
        expect_seq(6733, CAUSE_BOTH, 1'b1);
        pulse_sw(6733);
        to_cycle(6800); wdt_enable = 1'b0;
        to_cycle(6850); chk("both seq done", int'(busy), 0);
        base = 6860;
`else
        // Watchdog inputs are ignored in this build
        to_cycle(710); wdt_enable = 1'b1;
        to_cycle(3000); wdt_enable = 1'b0;
        chk("no wdt launch", int'(busy), 0);
        base = 3010;
`endif

        // Feedback stuck high: timeout 4096 cycles after WAIT_LOW entry (cycle c+17)
        fb_stuck = 1'b1;
        c = base;
        expect_seq(c, CAUSE_SW, 1'b0);
        q_to.push_back(c + 4113);
        pulse_sw(c);
        to_cycle(c + 4112); chk("timeout not yet", int'(ack_timeout), 0);
        to_cycle(c + 4177);
        chk("timeout busy cleared", int'(busy), 0);
        chk("timeout sticky", int'(ack_timeout), 1);
        chk("timeout count", int'(reset_count), exp_count);
        fb_stuck = 1'b0;
        to_cycle(c + 4180); sys_reset = 1'b1;
        to_cycle(c + 4181); sys_reset = 1'b0;
        exp_count = 0;
        chk("timeout cleared", int'(ack_timeout), 0);

        // 260 completed sequences saturate the count
        c = c + 4200;
        for (int i = 0; i < 260; i++) begin
            expect_seq(c, CAUSE_SW, 1'b1);
            pulse_sw(c);
            c = c + 116;
        end
        to_cycle(c);
        chk("saturated count", int'(reset_count), 255);
        chk("final busy", int'(busy), 0);

        to_cycle(c + 5);
        chk("leftover req_ack expectations", q_ack.size(), 0);
        chk("leftover reset_done expectations", q_done.size(), 0);
        chk("leftover timeout expectations", q_to.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
